req_pending_latch: RTL and testbench
====================================

Name: req_pending_latch

Overview:
- Upstream stage of the MSB-position priority encoder (priority_cd).
- Edge-detects a vector of request lines and holds each event as a pending bit until it is served.
- Drives the masked pending vector into the encoder and captures the encoded index it returns.
- Offers that index as a grant on a valid/ready handshake, clearing the served bit on acceptance.

Parameters:
- IN_WIDTH, 8, number of request lines; same value as the encoder's IN_WIDTH.
- OUT_WIDTH, $clog2(IN_WIDTH), localparam; index width; same value as the encoder's OUT_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_i  input  IN_WIDTH  request lines; a 0->1 transition is an event.
- mask_i  input  IN_WIDTH  1 = line enabled for arbitration; pending bits are kept even while masked.
- pend_o  output  IN_WIDTH  combinational vector to the encoder's "in".
- idx_i  input  OUT_WIDTH  encoder "out"; combinational function of pend_o, same cycle.
- gnt_valid_o  output  1  grant offered.
- gnt_idx_o  output  OUT_WIDTH  granted line index; stable while gnt_valid_o=1.
- gnt_ready_i  input  1  consumer accepts the grant.
- ovf_o  output  IN_WIDTH  sticky per-line overflow flags.
- ovf_clr_i  input  1  clears all of ovf_o.

Behaviour:
- Reset (async assert, sync release): pend=0, req_q=0, gnt_valid_o=0, gnt_idx_o=0, ovf_o=0, state=IDLE.
  - Because req_q=0, a line held high through reset registers an event on the first edge after release.
- Edge detect: rise = req_i & ~req_q; req_q <= req_i every cycle.
- pend_o = pend & mask_i & ~inflight.
  - inflight = onehot(gnt_idx_o) in OFFER, 0 in IDLE.
- FSM, IDLE:
  - If |pend_o: gnt_idx_o <= idx_i, gnt_valid_o <= 1, go to OFFER.
  - Otherwise stay in IDLE.
- FSM, OFFER:
  - gnt_valid_o and gnt_idx_o hold until gnt_ready_i=1.
  - On gnt_valid_o & gnt_ready_i: clear pend[gnt_idx_o], gnt_valid_o <= 0, go to IDLE (one bubble cycle).
- Pending update: pend <= (pend & ~clr) | rise; a set beats a clear on the same bit in the same cycle.
- Overflow: ovf_o[k] <= 1 when rise[k] and pend[k] is already 1, unless pend[k] is being cleared that cycle.
  - ovf_clr_i clears all bits.
  - A set in the same cycle beats ovf_clr_i.
- Latency:
  - Rising req_i sampled at edge N sets pend after edge N.
  - gnt_valid_o rises after edge N+1 at earliest.
- Mask changes while in OFFER do not withdraw a grant already offered.
- idx_i is ignored whenever pend_o==0; the encoder outputs 0 for a zero input.
- Priority is the highest set index, as determined by the encoder; this block adds no reordering.
- No behaviour change at wrap-around; IN_WIDTH a power of two ≥ 2.

Optional Feature:
- Macro GNT_BACK2BACK_EN.
- Defined: in OFFER, on a handshake with |pend_o (in-flight bit already excluded):
  - gnt_idx_o <= idx_i and gnt_valid_o stays 1, with no bubble;
  - throughput is one grant per cycle.
- Undefined: one mandatory IDLE cycle after each handshake; throughput is one grant per 2 cycles.

Test Plan:
- Reset and single event: hold rst_n=0 with req_i=8'h00; release; pulse req_i[5] for 1 cycle; mask_i=8'hFF.
  - Required: gnt_valid_o=1, gnt_idx_o=5 two edges after the pulse.
  - With gnt_ready_i=1: pend_o=0 next cycle, gnt_valid_o=0.
- Priority ordering: pulse req_i=8'h92 in one cycle; gnt_ready_i always 1.
  - Without macro: grants 7, 4, 1 on every other cycle.
  - With GNT_BACK2BACK_EN: grants 7, 4, 1 on consecutive cycles.
- Stall and mask: raise req[3]; hold gnt_ready_i=0 for 10 cycles; change mask_i to 8'h00 mid-stall.
  - Required: gnt_idx_o=3 stable and gnt_valid_o=1 throughout.
  - After acceptance: no new grant while masked; pend bit 3 was cleared.
- Overflow and set-beats-clear:
  - Re-pulse req[2] while pend[2]=1 and not being accepted: ovf_o=8'h04.
  - Pulse req[2] in the handshake cycle: pend[2] stays 1 and a second grant of 2 follows.
  - Pulse ovf_clr_i: ovf_o=0.
- Reset mid-operation: drop rst_n asynchronously while in OFFER with pend=8'hA0.
  - Required: all outputs 0 immediately, before the next clk edge.
  - After release: no grant unless a new rise occurs, or req_i is still held high.
- Sweep: drive req_i=0..255 incrementing each cycle, gnt_ready_i=1.
  - Every grant index equals the MSB of the masked pending vector at offer time.
  - No grant is ever issued for a bit with mask_i=0.

Source files
------------

// File: rtl/req_pending_latch.sv
// Latches request rises as pending bits, feeds an external MSB encoder, and offers its index as a
// grant (earliest 2 edges after a rise, held while !gnt_ready_i); `GNT_BACK2BACK_EN removes the post-grant bubble.
module req_pending_latch #(
  parameter  int IN_WIDTH  = 8,
  localparam int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  req_i,
  input  logic [IN_WIDTH-1:0]  mask_i,
  output logic [IN_WIDTH-1:0]  pend_o,
  input  logic [OUT_WIDTH-1:0] idx_i,
  output logic                 gnt_valid_o,
  output logic [OUT_WIDTH-1:0] gnt_idx_o,
  input  logic                 gnt_ready_i,
  output logic [IN_WIDTH-1:0]  ovf_o,
  input  logic                 ovf_clr_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IN_WIDTH-1:0]   r_req_q;
  logic [IN_WIDTH-1:0]   r_pend;
  logic [IN_WIDTH-1:0]   r_ovf;
  logic                  r_gnt_valid;
  logic [OUT_WIDTH-1:0]  r_gnt_idx;
  logic                  w_gnt_valid_nxt;
  logic [OUT_WIDTH-1:0]  w_gnt_idx_nxt;
  logic [IN_WIDTH-1:0]   w_rise;
  logic [IN_WIDTH-1:0]   w_gnt_onehot;
  logic [IN_WIDTH-1:0]   w_inflight;
  logic [IN_WIDTH-1:0]   w_clr;
  logic [IN_WIDTH-1:0]   w_pend_vis;
  logic                  w_any;
  logic                  w_hs;

  assign w_rise       = req_i & ~r_req_q;
  assign w_gnt_onehot = {{(IN_WIDTH-1){1'b0}}, 1'b1} << r_gnt_idx;
  // The line currently on offer is hidden from the encoder so a back-to-back pick sees the next one.
  assign w_inflight   = (r_state == OFFER) ? w_gnt_onehot : '0;
  assign w_pend_vis   = r_pend & mask_i & ~w_inflight;
  assign w_any        = |w_pend_vis;
  assign w_hs         = r_gnt_valid & gnt_ready_i;
  assign w_clr        = w_hs ? w_gnt_onehot : '0;

  assign pend_o      = w_pend_vis;
  assign gnt_valid_o = r_gnt_valid;
  assign gnt_idx_o   = r_gnt_idx;
  assign ovf_o       = r_ovf;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_idx_nxt   = r_gnt_idx;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_idx_nxt   = idx_i;
          w_gnt_valid_nxt = 1'b1;
          w_state_nxt     = OFFER;
        end
      end
      OFFER: begin
        if (w_hs) begin
`ifdef GNT_BACK2BACK_EN
          if (w_any) begin
            w_gnt_idx_nxt = idx_i;
          end else begin
            w_gnt_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
`else
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= '0;
      r_pend  <= '0;
      r_ovf   <= '0;
    end else begin
      r_req_q <= req_i;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      // A rise on a bit that is being served this cycle is a fresh event, not an overflow.
      r_ovf   <= (ovf_clr_i ? '0 : r_ovf) | (w_rise & r_pend & ~w_clr);
    end
  end

endmodule

// File: tb/tb_req_pending_latch.sv
// Directed bench for req_pending_latch with a behavioural MSB encoder driving idx_i.
module tb_req_pending_latch;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic [7:0] pend_o;
  logic [2:0] idx_i;
  logic       gnt_valid_o;
  logic [2:0] gnt_idx_o;
  logic       gnt_ready_i;
  logic [7:0] ovf_o;
  logic       ovf_clr_i;

  int n_cmp;
  int n_bad;

  req_pending_latch #(.IN_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .mask_i      (mask_i),
    .pend_o      (pend_o),
    .idx_i       (idx_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_ready_i (gnt_ready_i),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  function automatic logic [2:0] msb(input logic [7:0] v);
    msb = 3'd0;
    for (int k = 0; k < 8; k++) if (v[k]) msb = k[2:0];
  endfunction

  always_comb idx_i = msb(pend_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 8'h00; mask_i = 8'hFF; gnt_ready_i = 1'b0; ovf_clr_i = 1'b0;
    repeat (3) nxt();
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid_o); end
    n_cmp++; if (gnt_idx_o !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx_o); end
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL reset_pend got=%h want=00", pend_o); end
    n_cmp++; if (ovf_o !== 8'h00) begin n_bad++; $display("FAIL reset_ovf got=%h want=00", ovf_o); end
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_single();
    req_i = 8'h20; nxt();
    req_i = 8'h00; nxt();
    n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b want=1", gnt_valid_o); end
    n_cmp++; if (gnt_idx_o !== 3'd5) begin n_bad++; $display("FAIL single_idx got=%0d want=5", gnt_idx_o); end
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL single_inflight got=%h want=00", pend_o); end
    gnt_ready_i = 1'b1; nxt();
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_done_valid got=%b want=0", gnt_valid_o); end
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL single_done_pend got=%h want=00", pend_o); end
  endtask

  task automatic test_priority();
    bit ev [8];
    int ei [8];
`ifdef GNT_BACK2BACK_EN
    ev = '{0, 1, 1, 1, 0, 0, 0, 0};
    ei = '{0, 7, 4, 1, 0, 0, 0, 0};
`else
    ev = '{0, 1, 0, 1, 0, 1, 0, 0};
    ei = '{0, 7, 0, 4, 0, 1, 0, 0};
`endif
    gnt_ready_i = 1'b1;
    req_i = 8'h92; nxt();
    req_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      n_cmp++; if (gnt_valid_o !== ev[i]) begin n_bad++; $display("FAIL prio_valid[%0d] got=%b want=%b", i, gnt_valid_o, ev[i]); end
      if (ev[i]) begin
        n_cmp++; if (gnt_idx_o !== ei[i][2:0]) begin n_bad++; $display("FAIL prio_idx[%0d] got=%0d want=%0d", i, gnt_idx_o, ei[i]); end
      end
    end
  endtask

  task automatic test_stall_mask();
    gnt_ready_i = 1'b0;
    req_i = 8'h08; nxt();
    req_i = 8'h00; nxt();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, gnt_valid_o); end
      n_cmp++; if (gnt_idx_o !== 3'd3) begin n_bad++; $display("FAIL stall_idx[%0d] got=%0d want=3", i, gnt_idx_o); end
      if (i == 4) mask_i = 8'h00;
      nxt();
    end
    gnt_ready_i = 1'b1; nxt();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL masked_valid[%0d] got=%b want=0", i, gnt_valid_o); end
      nxt();
    end
    mask_i = 8'hFF; nxt();
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL stall_cleared_pend got=%h want=00", pend_o); end
    nxt();
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_cleared_valid got=%b want=0", gnt_valid_o); end
  endtask

  task automatic test_overflow();
    gnt_ready_i = 1'b0;
    req_i = 8'h04; nxt();
    req_i = 8'h00; nxt();
    n_cmp++; if (gnt_idx_o !== 3'd2) begin n_bad++; $display("FAIL ovf_first_idx got=%0d want=2", gnt_idx_o); end
    n_cmp++; if (ovf_o !== 8'h00) begin n_bad++; $display("FAIL ovf_initial got=%h want=00", ovf_o); end
    req_i = 8'h04; nxt();
    req_i = 8'h00;
    n_cmp++; if (ovf_o !== 8'h04) begin n_bad++; $display("FAIL ovf_set got=%h want=04", ovf_o); end
    nxt();
    req_i = 8'h04; gnt_ready_i = 1'b1; nxt();
    req_i = 8'h00; gnt_ready_i = 1'b0;
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL sbc_bubble got=%b want=0", gnt_valid_o); end
    n_cmp++; if (pend_o !== 8'h04) begin n_bad++; $display("FAIL sbc_pend got=%h want=04", pend_o); end
    n_cmp++; if (ovf_o !== 8'h04) begin n_bad++; $display("FAIL sbc_ovf got=%h want=04", ovf_o); end
    nxt();
    n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL sbc_regrant_valid got=%b want=1", gnt_valid_o); end
    n_cmp++; if (gnt_idx_o !== 3'd2) begin n_bad++; $display("FAIL sbc_regrant_idx got=%0d want=2", gnt_idx_o); end
    gnt_ready_i = 1'b1; nxt();
    gnt_ready_i = 1'b0;
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL sbc_drained got=%h want=00", pend_o); end
    req_i = 8'h40; nxt();
    req_i = 8'h00; nxt();
    n_cmp++; if (gnt_idx_o !== 3'd6) begin n_bad++; $display("FAIL ovf6_idx got=%0d want=6", gnt_idx_o); end
    req_i = 8'h40; ovf_clr_i = 1'b1; nxt();
    req_i = 8'h00; ovf_clr_i = 1'b0;
    n_cmp++; if (ovf_o !== 8'h40) begin n_bad++; $display("FAIL ovf_set_beats_clr got=%h want=40", ovf_o); end
    ovf_clr_i = 1'b1; nxt();
    ovf_clr_i = 1'b0;
    n_cmp++; if (ovf_o !== 8'h00) begin n_bad++; $display("FAIL ovf_clr got=%h want=00", ovf_o); end
    gnt_ready_i = 1'b1; nxt();
    gnt_ready_i = 1'b0;
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_valid got=%b want=0", gnt_valid_o); end
  endtask

  task automatic test_reset_mid();
    gnt_ready_i = 1'b0;
    req_i = 8'hA0; nxt();
    req_i = 8'h00; nxt();
    n_cmp++; if (gnt_idx_o !== 3'd7) begin n_bad++; $display("FAIL rmid_pre_idx got=%0d want=7", gnt_idx_o); end
    #2;
    rst_n = 1'b0; req_i = 8'h01;
    #1;
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b want=0", gnt_valid_o); end
    n_cmp++; if (gnt_idx_o !== 3'd0) begin n_bad++; $display("FAIL rmid_idx got=%0d want=0", gnt_idx_o); end
    n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL rmid_pend got=%h want=00", pend_o); end
    n_cmp++; if (ovf_o !== 8'h00) begin n_bad++; $display("FAIL rmid_ovf got=%h want=00", ovf_o); end
    nxt();
    rst_n = 1'b1; nxt();
    n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_rel_valid got=%b want=0", gnt_valid_o); end
    n_cmp++; if (pend_o !== 8'h01) begin n_bad++; $display("FAIL rmid_rel_pend got=%h want=01", pend_o); end
    nxt();
    n_cmp++; if (gnt_valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_held_valid got=%b want=1", gnt_valid_o); end
    n_cmp++; if (gnt_idx_o !== 3'd0) begin n_bad++; $display("FAIL rmid_held_idx got=%0d want=0", gnt_idx_o); end
    gnt_ready_i = 1'b1; nxt();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (gnt_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet[%0d] got=%b want=0", i, gnt_valid_o); end
      n_cmp++; if (pend_o !== 8'h00) begin n_bad++; $display("FAIL rmid_quiet_pend[%0d] got=%h want=00", i, pend_o); end
      nxt();
    end
    req_i = 8'h00;
  endtask

  task automatic test_sweep();
    logic [7:0] mp, pq, vis, oh, clr, rise;
    logic       mv;
    logic [2:0] mi;
    mask_i = 8'hF5; gnt_ready_i = 1'b1; req_i = 8'h00;
    nxt();
    mp = 8'h00; pq = 8'h00; mv = 1'b0; mi = 3'd0;
    for (int n = 0; n < 264; n++) begin
      req_i = (n < 256) ? n[7:0] : 8'h00;
      nxt();
      rise = req_i & ~pq;
      oh   = 8'h01 << mi;
      vis  = mp & mask_i & ~(mv ? oh : 8'h00);
      clr  = (mv && gnt_ready_i) ? oh : 8'h00;
      if (!mv) begin
        if (vis != 8'h00) begin mv = 1'b1; mi = msb(vis); end
      end else begin
`ifdef GNT_BACK2BACK_EN
        if (vis != 8'h00) mi = msb(vis);
        else mv = 1'b0;
`else
        mv = 1'b0;
`endif
      end
      mp = (mp & ~clr) | rise;
      pq = req_i;
      n_cmp++; if (gnt_valid_o !== mv) begin n_bad++; $display("FAIL sweep_valid[%0d] got=%b want=%b", n, gnt_valid_o, mv); end
      if (mv) begin
        n_cmp++; if (gnt_idx_o !== mi) begin n_bad++; $display("FAIL sweep_idx[%0d] got=%0d want=%0d", n, gnt_idx_o, mi); end
      end
      if (gnt_valid_o === 1'b1) begin
        n_cmp++; if (mask_i[gnt_idx_o] !== 1'b1) begin n_bad++; $display("FAIL sweep_masked_grant[%0d] got=idx%0d want=enabled line", n, gnt_idx_o); end
      end
      oh = 8'h01 << mi;
      n_cmp++; if (pend_o !== (mp & mask_i & ~(mv ? oh : 8'h00))) begin n_bad++; $display("FAIL sweep_pend[%0d] got=%h want=%h", n, pend_o, mp & mask_i & ~(mv ? oh : 8'h00)); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_priority();
    test_stall_mask();
    test_overflow();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
